// File: rtl/clkspec_arbtst_pkg.sv
// Shared types and defaults for the arbiter-test server and its client-side bench.
package clkspec_arbtst_pkg;

    localparam int NUM_CLIENTS_DEF = 2;
    localparam int WIDTH_DEF       = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESULT  = 2'b11
    } state_e;

endpackage

// File: rtl/clkspec_arbtst_server_if.sv
// Client/server handshake bundle: requests and operands in, grant and result strobes out.
interface clkspec_arbtst_server_if
    import clkspec_arbtst_pkg::*;
#(
    parameter int NUM_CLIENTS = NUM_CLIENTS_DEF,
    parameter int WIDTH       = WIDTH_DEF
) ();

    logic [NUM_CLIENTS-1:0]       req;
    logic [NUM_CLIENTS*WIDTH-1:0] ain;
    logic [NUM_CLIENTS*WIDTH-1:0] bin;
    logic [NUM_CLIENTS-1:0]       gnt;
    logic [WIDTH-1:0]             yout;
    logic [NUM_CLIENTS-1:0]       yvalid;
    logic                         busy;

    modport master (output req, ain, bin, input gnt, yout, yvalid, busy);
    modport slave  (input req, ain, bin, output gnt, yout, yvalid, busy);

endinterface

// File: rtl/clkspec_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after 'last', wrapping.
module clkspec_rr_arbiter #(
    parameter int N = 2,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic          any,
    output logic [LW-1:0] winner,
    output logic [N-1:0]  onehot
);

    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = int'(last) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                winner = j[LW-1:0];
            end
        end
        onehot = any ? ({{(N-1){1'b0}}, 1'b1} << winner) : '0;
    end

endmodule

// File: rtl/clkspec_arbtst_server.sv
// Round-robin adder server: grant, capture operands, return a+b with a one-hot strobe.
// Build option: define CLKSPEC_ARBTST_SAT_EN to saturate the sum instead of wrapping.
module clkspec_arbtst_server
    import clkspec_arbtst_pkg::*;
#(
    parameter int NUM_CLIENTS = NUM_CLIENTS_DEF,
    parameter int WIDTH       = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    clkspec_arbtst_server_if.slave  bus
);

    localparam int LW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    state_e                 state_q, state_d;
    logic [LW-1:0]          idx_q, idx_d;
    logic [LW-1:0]          last_q, last_d;
    logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
    logic [NUM_CLIENTS-1:0] yvalid_q, yvalid_d;
    logic [WIDTH-1:0]       yout_q, yout_d;

    logic                   arb_any;
    logic [LW-1:0]          arb_win;
    logic [NUM_CLIENTS-1:0] arb_oh;

    clkspec_rr_arbiter #(.N(NUM_CLIENTS)) u_arb (
        .req    (bus.req),
        .last   (last_q),
        .any    (arb_any),
        .winner (arb_win),
        .onehot (arb_oh)
    );

    logic [WIDTH-1:0] a_sel, b_sel;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_res;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (idx_q == LW'(i)) begin
                a_sel = bus.ain[i*WIDTH +: WIDTH];
                b_sel = bus.bin[i*WIDTH +: WIDTH];
            end
        end
        sum_full = {1'b0, a_sel} + {1'b0, b_sel};
`ifdef CLKSPEC_ARBTST_SAT_EN
        sum_res = sum_full[WIDTH] ? '1 : sum_full[WIDTH-1:0];
`else
        sum_res = sum_full[WIDTH-1:0];
`endif
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        gnt_d    = '0;
        yvalid_d = '0;
        yout_d   = yout_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    idx_d   = arb_win;
                    last_d  = arb_win;
                    gnt_d   = arb_oh;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT:   state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                yout_d   = sum_res;
                yvalid_d = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << idx_q;
                state_d  = ST_RESULT;
            end
            ST_RESULT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pointer resets to the top client so client 0 wins the first arbitration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            last_q   <= LW'(NUM_CLIENTS-1);
            gnt_q    <= '0;
            yvalid_q <= '0;
            yout_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            yvalid_q <= yvalid_d;
            yout_q   <= yout_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.yvalid = yvalid_q;
    assign bus.yout   = yout_q;
    assign bus.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clkspec_arbtst_server.sv
// Self-checking bench: transaction-level model compared every cycle plus directed literal checks.
module tb_clkspec_arbtst_server;

    localparam int NC = 4;
    localparam int W  = 4;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    clkspec_arbtst_server_if #(.NUM_CLIENTS(NC), .WIDTH(W)) bus ();

    clkspec_arbtst_server #(.NUM_CLIENTS(NC), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NC-1:0] r);
        for (int k = 1; k <= NC; k++)
            if (r[(last + k) % NC]) return (last + k) % NC;
        return 0;
    endfunction

    function automatic int add_model(input int a, input int b);
        int s;
        s = a + b;
`ifdef CLKSPEC_ARBTST_SAT_EN
        if (s > (1 << W) - 1) s = (1 << W) - 1;
`else
        s = s % (1 << W);
`endif
        return s;
    endfunction

    // Model: a transaction accepted at edge k yields gnt after k, yvalid after k+2,
    // busy through k+2, and the server can accept again from edge k+4.
    int         n_edge, acc_edge, last_w, cur_w;
    logic [NC-1:0] m_gnt, m_yv;
    logic [W-1:0]  m_yout;
    bit            m_busy;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_edge   = 0;
            acc_edge = -100;
            last_w   = NC - 1;
            cur_w    = 0;
            m_gnt    = '0;
            m_yv     = '0;
            m_yout   = '0;
            m_busy   = 1'b0;
        end else begin
            int d;
            n_edge++;
            d = n_edge - acc_edge;
            if (d >= 4 && bus.req != '0) begin
                cur_w    = rr_pick(last_w, bus.req);
                last_w   = cur_w;
                acc_edge = n_edge;
                d        = 0;
            end
            m_gnt  = (d == 0) ? NC'(1 << cur_w) : '0;
            m_yv   = (d == 2) ? NC'(1 << cur_w) : '0;
            m_busy = (d <= 2);
            if (d == 2)
                m_yout = W'(add_model(int'(bus.ain[cur_w*W +: W]), int'(bus.bin[cur_w*W +: W])));
        end
    end

    logic [NC-1:0] gnt_h1, gnt_h2;
    bit            prev_busy;

    always @(negedge clk) begin
        if (reset) begin
            chk("model_gnt",    bus.gnt,    m_gnt);
            chk("model_yvalid", bus.yvalid, m_yv);
            chk("model_yout",   bus.yout,   m_yout);
            chk("model_busy",   bus.busy,   m_busy);
            chk("gnt_onehot0",  $onehot0(bus.gnt), 1);
            chk("yv_onehot0",   $onehot0(bus.yvalid), 1);
            chk("gnt_yv_overlap", int'(bus.gnt != '0 && bus.yvalid != '0), 0);
            chk("gnt_to_yvalid", bus.yvalid, gnt_h2);
            chk("gnt_after_busy", int'(bus.gnt != '0 && prev_busy), 0);
            gnt_h2    = gnt_h1;
            gnt_h1    = bus.gnt;
            prev_busy = bus.busy;
        end else begin
            gnt_h1    = '0;
            gnt_h2    = '0;
            prev_busy = 1'b0;
        end
    end

    task automatic set_ops(input int c, input int a, input int b);
        bus.ain[c*W +: W] = W'(a);
        bus.bin[c*W +: W] = W'(b);
    endtask

    task automatic wait_pulse(input bit want_yv, input string name,
                              output logic [NC-1:0] v, output logic [W-1:0] y);
        bit seen;
        seen = 1'b0;
        v = '0;
        y = '0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (want_yv ? (bus.yvalid != '0) : (bus.gnt != '0)) begin
                seen = 1'b1;
                v = want_yv ? bus.yvalid : bus.gnt;
                y = bus.yout;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no pulse within 10 cycles", name);
        end
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        logic [NC-1:0] v;
        logic [W-1:0]  y;
        logic [NC-1:0] rr_v [4];
        logic [W-1:0]  rr_y [4];
        rr_v = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        rr_y = '{4'd2, 4'd7, 4'd2, 4'd7};

        reset   = 1'b0;
        bus.req = '0;
        bus.ain = '0;
        bus.bin = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_yvalid", bus.yvalid, 0);
        chk("rst_yout", bus.yout, 0);
        chk("rst_busy", bus.busy, 0);
        #2 reset = 1'b1;

        // single request from client 0: 3+4
        @(negedge clk);
        set_ops(0, 3, 4);
        bus.req = 4'b0001;
        wait_pulse(1'b0, "single_gnt_wait", v, y);
        chk("single_gnt", v, 1);
        bus.req = '0;
        wait_pulse(1'b1, "single_yv_wait", v, y);
        chk("single_yvalid", v, 1);
        chk("single_yout", y, 7);
        @(negedge clk);
        chk("single_busy_after", bus.busy, 0);

        // round-robin with two clients held high from a fresh pointer
        pulse_reset();
        set_ops(0, 1, 1);
        set_ops(1, 2, 5);
        bus.req = 4'b0011;
        for (int t = 0; t < 4; t++) begin
            wait_pulse(1'b0, "rr_gnt_wait", v, y);
            chk("rr_gnt", v, rr_v[t]);
            wait_pulse(1'b1, "rr_yv_wait", v, y);
            chk("rr_yvalid", v, rr_v[t]);
            chk("rr_yout", y, rr_y[t]);
        end
        bus.req = '0;

        // overflow: 9+9 wraps to 2, or saturates to 15
        set_ops(2, 9, 9);
        bus.req = 4'b0100;
        wait_pulse(1'b0, "ovf_gnt_wait", v, y);
        chk("ovf_gnt", v, 4);
        bus.req = '0;
        wait_pulse(1'b1, "ovf_yv_wait", v, y);
        chk("ovf_yvalid", v, 4);
`ifdef CLKSPEC_ARBTST_SAT_EN
        chk("ovf_yout", y, 15);
`else
        chk("ovf_yout", y, 2);
`endif
        set_ops(3, 15, 0);
        bus.req = 4'b1000;
        wait_pulse(1'b0, "max_gnt_wait", v, y);
        chk("max_gnt", v, 8);
        bus.req = '0;
        wait_pulse(1'b1, "max_yv_wait", v, y);
        chk("max_yout", y, 15);

        // request held for exactly one IDLE cycle
        @(negedge clk);
        set_ops(0, 6, 5);
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = '0;
        chk("drop_gnt", bus.gnt, 1);
        wait_pulse(1'b1, "drop_yv_wait", v, y);
        chk("drop_yvalid", v, 1);
        chk("drop_yout", y, 11);
        @(negedge clk);
        chk("drop_busy_after", bus.busy, 0);

        // reset asserted during CAPTURE
        set_ops(1, 7, 7);
        bus.req = 4'b0010;
        wait_pulse(1'b0, "midrst_gnt_wait", v, y);
        chk("midrst_gnt", v, 2);
        bus.req = '0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_gnt0", bus.gnt, 0);
        chk("midrst_yv0", bus.yvalid, 0);
        chk("midrst_yout0", bus.yout, 0);
        chk("midrst_busy0", bus.busy, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        bus.req = 4'b0011;
        wait_pulse(1'b0, "postrst_gnt_wait", v, y);
        chk("postrst_gnt", v, 1);
        bus.req = '0;
        wait_pulse(1'b1, "postrst_yv_wait", v, y);
        chk("postrst_yout", y, 11);

        // random traffic, checked by the model and protocol checks
        repeat (400) begin
            @(negedge clk);
            bus.req = NC'($urandom_range(0, (1 << NC) - 1));
            bus.ain = (NC*W)'($urandom);
            bus.bin = (NC*W)'($urandom);
        end
        bus.req = '0;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
